// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port numbering and XY route computation.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // Dimension-order routing: correct X first, then Y (y grows southward), else deliver locally.
    function automatic port_e route_compute(
        input int unsigned dest_x,
        input int unsigned dest_y,
        input int unsigned here_x,
        input int unsigned here_y
    );
        port_e dir;
        if (dest_x > here_x) begin
            dir = PORT_E;
        end else if (dest_x < here_x) begin
            dir = PORT_W;
        end else if (dest_y > here_y) begin
            dir = PORT_S;
        end else if (dest_y < here_y) begin
            dir = PORT_N;
        end else begin
            dir = PORT_L;
        end
        return dir;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit buffer; a push is refused whenever the buffer is full, even if a pop happens too.
module router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values and storage contents for this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointers clear on reset, which empties the buffer regardless of stored data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mesh_router.sv
// Five-port XY mesh router: input FIFOs, round-robin output arbitration, one-flit output registers.
module mesh_router
    import noc_pkg::*;
#(
    parameter int FLIT_W = 16,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int XCOORD = 0,
    parameter int YCOORD = 0,
    parameter int DEPTH  = 4,
    parameter int HAS_N  = 1,
    parameter int HAS_S  = 1,
    parameter int HAS_E  = 1,
    parameter int HAS_W  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] in_valid,
    input  logic [FLIT_W-1:0]    in_data [NUM_PORTS],
    output logic [NUM_PORTS-1:0] in_ready,
    output logic [NUM_PORTS-1:0] out_valid,
    output logic [FLIT_W-1:0]    out_data [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [7:0]           drop_cnt,
    output logic                 err
);

    localparam logic [NUM_PORTS-1:0] PORT_EN = {1'b1, (HAS_W != 0), (HAS_E != 0), (HAS_S != 0), (HAS_N != 0)};

    logic [NUM_PORTS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, misroute;
    logic [FLIT_W-1:0]    head [NUM_PORTS];
    port_e                head_dir [NUM_PORTS];
    logic [NUM_PORTS-1:0] req [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_valid;
    logic [2:0]           grant_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]    out_data_q [NUM_PORTS];
    logic [FLIT_W-1:0]    out_data_d [NUM_PORTS];
    logic [2:0]           rr_ptr_q [NUM_PORTS];
    logic [2:0]           rr_ptr_d [NUM_PORTS];
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 err_q, err_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        assign in_ready[p]  = PORT_EN[p] && rst_n && !fifo_full[p];
        assign fifo_push[p] = in_valid[p] && in_ready[p];

        router_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[p]),
            .pop   (fifo_pop[p]),
            .wdata (in_data[p]),
            .rdata (head[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p])
        );

        assign head_dir[p] = route_compute(32'(head[p][X_W-1:0]), 32'(head[p][X_W+Y_W-1:X_W]),
                                           XCOORD, YCOORD);
        assign misroute[p] = !fifo_empty[p] && !PORT_EN[head_dir[p]];
    end

    // Build per-output request vectors from each input's head flit direction.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[o][p] = !fifo_empty[p] && (int'(head_dir[p]) == o) && PORT_EN[o];
            end
        end
    end

    // Round-robin grant per output, only when its register is empty or draining this cycle.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_idx[o] = '0;
            rr_ptr_d[o]  = rr_ptr_q[o];
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    cand = int'(rr_ptr_q[o]) + k;
                    if (cand >= NUM_PORTS) begin
                        cand = cand - NUM_PORTS;
                    end
                    if (!grant_valid[o] && req[o][cand]) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = 3'(cand);
                    end
                end
            end
            if (grant_valid[o]) begin
                rr_ptr_d[o] = (grant_idx[o] == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_idx[o] + 3'd1;
            end
        end
    end

    // Load granted flits into output registers and pop forwarded or misrouted heads.
    always_comb begin
        fifo_pop = misroute;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_valid_d[o] = out_valid_q[o] && !out_ready[o];
            out_data_d[o]  = out_data_q[o];
            if (grant_valid[o]) begin
                out_valid_d[o]          = 1'b1;
                out_data_d[o]           = head[grant_idx[o]];
                fifo_pop[grant_idx[o]]  = 1'b1;
            end
        end
    end

    // Saturating drop counter and sticky error flag; several inputs may drop in one cycle.
    always_comb begin
        int drop_sum;
        drop_sum   = int'(drop_cnt_q) + $countones(misroute);
        drop_cnt_d = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
        err_d      = err_q || (|misroute);
    end

    // Router state registers, all cleared asynchronously so no partial output survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
            err_q       <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            err_q       <= err_d;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_q[o] <= out_data_d[o];
                rr_ptr_q[o]   <= rr_ptr_d[o];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign drop_cnt  = drop_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mesh_router.sv
// Directed testbench for mesh_router: a fully enabled router at (1,1) and a north-less router at (0,1).
module tb_mesh_router;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [4:0]  in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [15:0] in_data_a [5];
    logic [15:0] out_data_a [5];
    logic [7:0]  drop_cnt_a;
    logic        err_a;

    logic [4:0]  in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [15:0] in_data_b [5];
    logic [15:0] out_data_b [5];
    logic [7:0]  drop_cnt_b;
    logic        err_b;

    int test_count;
    int fail_count;

    always #5 clk = ~clk;

    mesh_router #(
        .XCOORD (1),
        .YCOORD (1)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_ready (out_ready_a),
        .drop_cnt  (drop_cnt_a),
        .err       (err_a)
    );

    mesh_router #(
        .XCOORD (0),
        .YCOORD (1),
        .HAS_N  (0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_ready (out_ready_b),
        .drop_cnt  (drop_cnt_b),
        .err       (err_b)
    );

    // Flit layout: dest_x in [1:0], dest_y in [3:2], a 12-bit tag above.
    function automatic logic [15:0] mk_flit(input int x, input int y, input int tag);
        return {tag[11:0], y[1:0], x[1:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present one flit on router A for a single clock edge; called and returns on a falling edge.
    task automatic applyStimulus(input int port, input logic [15:0] flit);
        in_valid_a[port] = 1'b1;
        in_data_a[port]  = flit;
        @(negedge clk);
        in_valid_a[port] = 1'b0;
    endtask

    initial begin
        logic [15:0] f1, f_n, f_s, f_w, f_ns, f_sn, f_e, f_loc;
        logic [15:0] bp_flit [5];
        logic [4:0]  seen;

        test_count  = 0;
        fail_count  = 0;
        rst_n       = 1'b0;
        in_valid_a  = '0;
        in_valid_b  = '0;
        out_ready_a = 5'h1f;
        out_ready_b = 5'h1f;
        for (int i = 0; i < 5; i++) begin
            in_data_a[i] = '0;
            in_data_b[i] = '0;
        end

        // Reset state
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready_a), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid_a), 32'h0);
        checkOutput("reset_drop_cnt", 32'(drop_cnt_a), 32'h0);
        checkOutput("reset_err", 32'(err_a), 32'h0);
        checkOutput("reset_out_data_e", 32'(out_data_a[2]), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset_a", 32'(in_ready_a), 32'h1f);
        checkOutput("ready_after_reset_b", 32'(in_ready_b), 32'h1e);
        @(negedge clk);

        // Uncontended latency: L -> E
        f1 = mk_flit(3, 1, 'h0AB);
        applyStimulus(4, f1);
        checkOutput("lat_not_early", 32'(out_valid_a), 32'h0);
        @(negedge clk);
        checkOutput("lat_valid_e", 32'(out_valid_a), 32'b00100);
        checkOutput("lat_data_e", 32'(out_data_a[2]), 32'(f1));
        @(negedge clk);
        checkOutput("lat_drained", 32'(out_valid_a), 32'h0);

        // Round robin: N, S, W all to local
        f_n = mk_flit(1, 1, 'h001);
        f_s = mk_flit(1, 1, 'h002);
        f_w = mk_flit(1, 1, 'h003);
        in_data_a[0] = f_n;
        in_data_a[1] = f_s;
        in_data_a[3] = f_w;
        in_valid_a   = 5'b01011;
        @(negedge clk);
        in_valid_a   = '0;
        @(negedge clk);
        checkOutput("rr_first_valid", 32'(out_valid_a), 32'b10000);
        checkOutput("rr_first_n", 32'(out_data_a[4]), 32'(f_n));
        @(negedge clk);
        checkOutput("rr_second_s", 32'(out_data_a[4]), 32'(f_s));
        @(negedge clk);
        checkOutput("rr_third_w", 32'(out_data_a[4]), 32'(f_w));
        checkOutput("rr_ptr_l", 32'(dut_a.rr_ptr_q[4]), 32'd4);
        @(negedge clk);
        checkOutput("rr_idle", 32'(out_valid_a), 32'h0);

        // Parallel crossing: N -> S and S -> N in the same cycle
        f_ns = mk_flit(1, 2, 'h004);
        f_sn = mk_flit(1, 0, 'h005);
        in_data_a[0] = f_ns;
        in_data_a[1] = f_sn;
        in_valid_a   = 5'b00011;
        @(negedge clk);
        in_valid_a   = '0;
        @(negedge clk);
        checkOutput("par_valid", 32'(out_valid_a), 32'b00011);
        checkOutput("par_data_s", 32'(out_data_a[1]), 32'(f_ns));
        checkOutput("par_data_n", 32'(out_data_a[0]), 32'(f_sn));
        @(negedge clk);

        // Backpressure on E: 4 flits buffered plus 1 held, then drain in order
        out_ready_a[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_flit[i] = mk_flit(2, 1, 'h100 + i);
            checkOutput($sformatf("bp_ready_%0d", i), 32'(in_ready_a[3]), 32'h1);
            applyStimulus(3, bp_flit[i]);
        end
        checkOutput("bp_full_ready", 32'(in_ready_a[3]), 32'h0);
        checkOutput("bp_hold_valid", 32'(out_valid_a[2]), 32'h1);
        checkOutput("bp_hold_data", 32'(out_data_a[2]), 32'(bp_flit[0]));
        @(negedge clk);
        checkOutput("bp_stable_data", 32'(out_data_a[2]), 32'(bp_flit[0]));
        out_ready_a[2] = 1'b1;
        in_valid_a[3]  = 1'b1;
        in_data_a[3]   = mk_flit(2, 1, 'hBAD);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            in_valid_a[3] = 1'b0;
            checkOutput($sformatf("bp_drain_valid_%0d", i), 32'(out_valid_a[2]), 32'h1);
            checkOutput($sformatf("bp_drain_data_%0d", i), 32'(out_data_a[2]), 32'(bp_flit[i]));
        end
        @(negedge clk);
        checkOutput("bp_no_extra", 32'(out_valid_a[2]), 32'h0);

        // Reset mid-operation with three flits in flight
        out_ready_a[2] = 1'b0;
        applyStimulus(4, mk_flit(3, 0, 'h201));
        applyStimulus(4, mk_flit(3, 0, 'h202));
        applyStimulus(4, mk_flit(3, 0, 'h203));
        checkOutput("rst_pre_valid", 32'(out_valid_a[2]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", 32'(out_valid_a), 32'h0);
        checkOutput("rst_async_ready", 32'(in_ready_a), 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_a = 5'h1f;
        seen        = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid_a;
        end
        checkOutput("rst_no_stale", 32'(seen), 32'h0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt_a), 32'h0);
        f_loc = mk_flit(1, 0, 'h300);
        applyStimulus(4, f_loc);
        @(negedge clk);
        checkOutput("rst_resume_valid", 32'(out_valid_a), 32'b00001);
        checkOutput("rst_resume_data", 32'(out_data_a[0]), 32'(f_loc));

        // Router B: disabled north port, misroute drop alongside a normal grant
        checkOutput("b_dis_out_valid", 32'(out_valid_b), 32'h0);
        f_e = mk_flit(0, 1, 'h00E);
        in_data_b[4] = mk_flit(0, 0, 'h001);
        in_data_b[2] = f_e;
        in_data_b[0] = mk_flit(0, 1, 'h077);
        in_valid_b   = 5'b10101;
        @(negedge clk);
        in_valid_b   = '0;
        @(negedge clk);
        checkOutput("b_drop_cnt_1", 32'(drop_cnt_b), 32'd1);
        checkOutput("b_err_set", 32'(err_b), 32'h1);
        checkOutput("b_grant_l_valid", 32'(out_valid_b), 32'b10000);
        checkOutput("b_grant_l_data", 32'(out_data_b[4]), 32'(f_e));
        checkOutput("b_dis_out_data", 32'(out_data_b[0]), 32'h0);
        @(negedge clk);
        checkOutput("b_dis_input_ignored", 32'(out_valid_b), 32'h0);
        checkOutput("b_drop_cnt_still_1", 32'(drop_cnt_b), 32'd1);

        // Drop counter: reach 200, then push 100 more and saturate at 255
        in_data_b[4]  = mk_flit(0, 0, 'h002);
        in_valid_b[4] = 1'b1;
        repeat (199) @(negedge clk);
        in_valid_b[4] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b_drop_cnt_200", 32'(drop_cnt_b), 32'd200);
        in_valid_b[4] = 1'b1;
        repeat (100) @(negedge clk);
        in_valid_b[4] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b_drop_cnt_sat", 32'(drop_cnt_b), 32'd255);
        checkOutput("b_err_sticky", 32'(err_b), 32'h1);
        checkOutput("b_no_out_after_drops", 32'(out_valid_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
